// File: rtl/palette_fade_ctrl_if.sv
// -----------------------------------------------------------------------------
// palette_fade_ctrl_if
//   Bundles the signals between the palette lookup/frame timing side and the
//   palette_fade_ctrl sequencer.
//
//   master : the surrounding video pipeline (drives requests, frame tick and the
//            looked-up palette colour; receives the scaled colour and status)
//   slave  : palette_fade_ctrl itself
//
//   frame_tick    one-cycle pulse per frame (vblank start)
//   fade_out_req  start fade to black (honoured only while fully bright)
//   fade_in_req   start fade from black (honoured only while black)
//   red/green/blue_in   4-bit palette colour
//   red/green/blue_out  4-bit scaled colour, registered
//   level         current brightness, 15 = full, 0 = black
//   busy          high while a fade is in progress
//   done          one-cycle pulse when a fade completes
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface palette_fade_ctrl_if;
  logic       frame_tick;
  logic       fade_out_req;
  logic       fade_in_req;
  logic [3:0] red_in;
  logic [3:0] green_in;
  logic [3:0] blue_in;
  logic [3:0] red_out;
  logic [3:0] green_out;
  logic [3:0] blue_out;
  logic [3:0] level;
  logic       busy;
  logic       done;

  modport master (
    output frame_tick, fade_out_req, fade_in_req,
    output red_in, green_in, blue_in,
    input  red_out, green_out, blue_out,
    input  level, busy, done
  );

  modport slave (
    input  frame_tick, fade_out_req, fade_in_req,
    input  red_in, green_in, blue_in,
    output red_out, green_out, blue_out,
    output level, busy, done
  );
endinterface

// File: rtl/palette_fade_ctrl.sv
// -----------------------------------------------------------------------------
// palette_fade_ctrl
//   Screen fade sequencer sitting between the palette colour lookup and the VGA
//   output stage. The looked-up 4-bit RGB is scaled by a brightness level to
//   give fade-to-black and fade-from-black transitions. Brightness only changes
//   on frame_tick, so a frame is never drawn with two different levels.
//
// Parameters
//   FRAME_DIV    frame_ticks per brightness step (>= 1)
//   HOLD_FRAMES  frame_ticks spent black before an automatic fade-in
//                (only with FADE_AUTO_RETURN_EN)
//
// Ports
//   Clk    system clock
//   Reset  synchronous, active-high; wins over everything, mid-fade included
//   bus    palette_fade_ctrl_if.slave (requests, frame tick, RGB in/out,
//          level, busy, done)
//
// Build option
//   FADE_AUTO_RETURN_EN : when defined, the black screen is held for
//   HOLD_FRAMES frame_ticks and then fades back in by itself. When undefined,
//   black is held until fade_in_req and no hold counter exists.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module palette_fade_ctrl #(
  parameter int FRAME_DIV   = 2,
  parameter int HOLD_FRAMES = 30
) (
  input logic                Clk,
  input logic                Reset,
  palette_fade_ctrl_if.slave bus
);

  localparam int DATA_W = 4;   // colour channel width
  localparam int COEF_W = 4;   // brightness level width

  localparam logic [COEF_W-1:0] LVL_MAX = '1;
  localparam logic [COEF_W-1:0] LVL_MIN = '0;

  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  // Parameter sanity: a zero divider or hold time has no meaning.
  if (FRAME_DIV < 1 || HOLD_FRAMES < 1) begin : g_param_check
    $error("palette_fade_ctrl: FRAME_DIV and HOLD_FRAMES must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_BRIGHT     = 2'd0,
    ST_FADING_OUT = 2'd1,
    ST_BLACK      = 2'd2,
    ST_FADING_IN  = 2'd3
  } state_t;

  state_t              state_q, state_nxt;
  logic [COEF_W-1:0]   level_q, level_nxt;
  logic [DIV_W-1:0]    div_q,   div_nxt;
  logic                busy_q,  busy_nxt;
  logic                done_q,  done_nxt;

`ifdef FADE_AUTO_RETURN_EN
  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
  logic [HOLD_W-1:0]   hold_q, hold_nxt;
`endif

  logic [DATA_W-1:0]   red_p1, green_p1, blue_p1;

  // c * (level + 1) >> 4: level 15 is a pass-through, level 0 gives black.
  // The product never exceeds 15 * 16 = 240, so the top bit stays clear.
  function automatic logic [DATA_W-1:0] scale_chan(
    input logic [DATA_W-1:0] c,
    input logic [COEF_W-1:0] lvl
  );
    logic [COEF_W:0]          gain;
    logic [DATA_W+COEF_W:0]   prod;
    gain = {1'b0, lvl} + (COEF_W+1)'(1);
    prod = {{(COEF_W+1){1'b0}}, c} * {{DATA_W{1'b0}}, gain};
    return prod[COEF_W +: DATA_W];
  endfunction

  // Next-state / next-control logic.
  always_comb begin
    state_nxt = state_q;
    level_nxt = level_q;
    div_nxt   = div_q;
    done_nxt  = 1'b0;
`ifdef FADE_AUTO_RETURN_EN
    hold_nxt  = hold_q;
`endif

    unique case (state_q)
      ST_BRIGHT: begin
        // A simultaneous fade_in_req is meaningless here and is dropped.
        if (bus.fade_out_req) begin
          state_nxt = ST_FADING_OUT;
          div_nxt   = '0;
        end
      end

      ST_FADING_OUT: begin
        if (bus.frame_tick) begin
          if (div_q == DIV_LAST) begin
            div_nxt = '0;
            if (level_q != LVL_MIN) begin
              level_nxt = level_q - COEF_W'(1);
            end
            if (level_q <= COEF_W'(1)) begin
              state_nxt = ST_BLACK;
              done_nxt  = 1'b1;
`ifdef FADE_AUTO_RETURN_EN
              hold_nxt  = '0;
`endif
            end
          end else begin
            div_nxt = div_q + DIV_W'(1);
          end
        end
      end

      ST_BLACK: begin
        // The tick that coincides with acceptance is not counted toward the
        // first brightness step.
        if (bus.fade_in_req) begin
          state_nxt = ST_FADING_IN;
          div_nxt   = '0;
`ifdef FADE_AUTO_RETURN_EN
          hold_nxt  = '0;
        end else if (bus.frame_tick) begin
          if (hold_q == HOLD_LAST) begin
            state_nxt = ST_FADING_IN;
            div_nxt   = '0;
            hold_nxt  = '0;
          end else begin
            hold_nxt = hold_q + HOLD_W'(1);
          end
`endif
        end
      end

      ST_FADING_IN: begin
        if (bus.frame_tick) begin
          if (div_q == DIV_LAST) begin
            div_nxt = '0;
            if (level_q != LVL_MAX) begin
              level_nxt = level_q + COEF_W'(1);
            end
            if (level_q >= (LVL_MAX - COEF_W'(1))) begin
              state_nxt = ST_BRIGHT;
              done_nxt  = 1'b1;
            end
          end else begin
            div_nxt = div_q + DIV_W'(1);
          end
        end
      end

      default: begin
        state_nxt = ST_BRIGHT;
        level_nxt = LVL_MAX;
        div_nxt   = '0;
      end
    endcase

    // busy is registered from the next state so it tracks state_q exactly.
    busy_nxt = (state_nxt == ST_FADING_OUT) || (state_nxt == ST_FADING_IN);
  end

  // ---- stage p1: control registers and scaled colour ----
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_BRIGHT;
      level_q  <= LVL_MAX;
      div_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef FADE_AUTO_RETURN_EN
      hold_q   <= '0;
`endif
      red_p1   <= '0;
      green_p1 <= '0;
      blue_p1  <= '0;
    end else begin
      state_q  <= state_nxt;
      level_q  <= level_nxt;
      div_q    <= div_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
`ifdef FADE_AUTO_RETURN_EN
      hold_q   <= hold_nxt;
`endif
      // Scaled with the level held at the start of this cycle.
      red_p1   <= scale_chan(bus.red_in,   level_q);
      green_p1 <= scale_chan(bus.green_in, level_q);
      blue_p1  <= scale_chan(bus.blue_in,  level_q);
    end
  end

  assign bus.red_out   = red_p1;
  assign bus.green_out = green_p1;
  assign bus.blue_out  = blue_p1;
  assign bus.level     = level_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
